// File: rtl/fe_fb_arb_pkg.sv
// Shared types for the fetch-buffer request arbiter and its id tracker.
package fe_fb_arb_pkg;

  typedef enum logic {
    OWN_DMD = 1'b0,
    OWN_PF  = 1'b1
  } t_fb_owner;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RUN   = 2'd1,
    ARB_HOLD  = 2'd2,
    ARB_DRAIN = 2'd3
  } t_arb_state;

  typedef struct packed {
    logic      alloc;
    logic      stale;
    t_fb_owner owner;
  } t_fb_id_entry;

  localparam t_fb_id_entry FB_ID_ENTRY_RST = '{alloc: 1'b0, stale: 1'b0, owner: OWN_DMD};

endpackage

// File: rtl/fe_fb_arb_id_tracker.sv
// Request id table: lowest-free search, alloc/free/stale marking, outstanding count.
// stale_pending exists only when FE_FB_ARB_DRAIN_EN is defined.
module fe_fb_id_tracker
  import fe_fb_arb_pkg::*;
#(
  parameter int ID_W  = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic [ID_W-1:0]  alloc_id,
  input  logic             alloc_pf,
  input  logic             rsp_valid,
  input  logic [ID_W-1:0]  rsp_id,
  output logic             rsp_alloc,
  output logic             rsp_stale,
  output logic             rsp_pf,
  output logic             free_avail,
  output logic [ID_W-1:0]  free_id,
`ifdef FE_FB_ARB_DRAIN_EN
  output logic             stale_pending,
`endif
  output logic [CNT_W-1:0] cnt
);

  localparam int NUM_ID = 1 << ID_W;

  t_fb_id_entry tbl     [NUM_ID];
  t_fb_id_entry tbl_nxt [NUM_ID];

  assign rsp_alloc = tbl[rsp_id].alloc;
  assign rsp_stale = tbl[rsp_id].stale;
  assign rsp_pf    = (tbl[rsp_id].owner == OWN_PF);

  // Downward scan so the last hit is the lowest free index.
  always_comb begin
    free_avail = 1'b0;
    free_id    = '0;
    cnt        = '0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (!tbl[i].alloc) begin
        free_avail = 1'b1;
        free_id    = ID_W'(i);
      end
      cnt = cnt + CNT_W'(tbl[i].alloc);
    end
  end

  // A response in a flush cycle still frees its entry; free overrides the stale mark.
  always_comb begin
    for (int i = 0; i < NUM_ID; i++) begin
      tbl_nxt[i] = tbl[i];
      if (flush && tbl[i].alloc)
        tbl_nxt[i].stale = 1'b1;
      if (rsp_valid && rsp_id == ID_W'(i) && tbl[i].alloc)
        tbl_nxt[i] = FB_ID_ENTRY_RST;
      if (alloc_en && alloc_id == ID_W'(i)) begin
        tbl_nxt[i].alloc = 1'b1;
        tbl_nxt[i].stale = 1'b0;
        tbl_nxt[i].owner = alloc_pf ? OWN_PF : OWN_DMD;
      end
    end
  end

`ifdef FE_FB_ARB_DRAIN_EN
  always_comb begin
    stale_pending = 1'b0;
    for (int i = 0; i < NUM_ID; i++)
      stale_pending = stale_pending | tbl_nxt[i].stale;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ID; i++)
        tbl[i] <= FB_ID_ENTRY_RST;
    end else begin
      tbl <= tbl_nxt;
    end
  end

endmodule

// File: rtl/fe_fb_arb.sv
// Fetch-buffer request arbiter: demand vs next-line prefetch, id allocation, response routing.
// Optional FE_FB_ARB_DRAIN_EN: after a flush, hold off grants until all stale ids return.
module fe_fb_arb
  import fe_fb_arb_pkg::*;
#(
  parameter int PADDR_W         = 32,
  parameter int ID_W            = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 dmd_req_valid,
  input  logic [PADDR_W-1:0]                   dmd_req_addr,
  output logic                                 dmd_req_gnt,
  input  logic                                 pf_req_valid,
  input  logic [PADDR_W-1:0]                   pf_req_addr,
  output logic                                 pf_req_gnt,
  output logic                                 fb_req_valid,
  output logic [PADDR_W-1:0]                   fb_req_addr,
  output logic [ID_W-1:0]                      fb_req_id,
  input  logic                                 fb_req_ready,
  input  logic                                 fb_rsp_valid,
  input  logic [ID_W-1:0]                      fb_rsp_id,
  output logic                                 dmd_rsp_valid,
  output logic                                 pf_rsp_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  t_arb_state      state, state_nxt;
  logic [SC_W-1:0] starve_cnt;
  logic            pf_sel, dmd_sel, can_issue;
  logic            rsp_alloc, rsp_stale, rsp_pf, rsp_live;
  logic            free_avail;
  logic [ID_W-1:0] free_id;
`ifdef FE_FB_ARB_DRAIN_EN
  logic            stale_pending;
`endif

  fe_fb_id_tracker #(
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_id_tracker (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .alloc_en      (dmd_req_gnt | pf_req_gnt),
    .alloc_id      (free_id),
    .alloc_pf      (pf_req_gnt),
    .rsp_valid     (fb_rsp_valid),
    .rsp_id        (fb_rsp_id),
    .rsp_alloc     (rsp_alloc),
    .rsp_stale     (rsp_stale),
    .rsp_pf        (rsp_pf),
    .free_avail    (free_avail),
    .free_id       (free_id),
`ifdef FE_FB_ARB_DRAIN_EN
    .stale_pending (stale_pending),
`endif
    .cnt           (outstanding_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: state_nxt = ARB_RUN;
      ARB_RUN:  if (flush) state_nxt = ARB_HOLD;
`ifdef FE_FB_ARB_DRAIN_EN
      ARB_HOLD: state_nxt = flush ? ARB_HOLD : ARB_DRAIN;
      // Looks at the table as it will be after this cycle's frees, so the
      // grant can follow the last stale response by exactly one cycle.
      ARB_DRAIN: begin
        if (flush)               state_nxt = ARB_HOLD;
        else if (!stale_pending) state_nxt = ARB_RUN;
      end
`else
      ARB_HOLD: state_nxt = flush ? ARB_HOLD : ARB_RUN;
`endif
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    pf_sel       = pf_req_valid & (~dmd_req_valid | (starve_cnt == SC_W'(STARVE_LIMIT)));
    dmd_sel      = dmd_req_valid & ~pf_sel;
    can_issue    = (state == ARB_RUN) & ~flush & free_avail
                   & (outstanding_cnt < CNT_W'(MAX_OUTSTANDING));
    fb_req_valid = can_issue & (pf_sel | dmd_sel);
    fb_req_addr  = '0;
    fb_req_id    = '0;
    if (fb_req_valid) begin
      fb_req_addr = pf_sel ? pf_req_addr : dmd_req_addr;
      fb_req_id   = free_id;
    end
    dmd_req_gnt = fb_req_valid & fb_req_ready & dmd_sel;
    pf_req_gnt  = fb_req_valid & fb_req_ready & pf_sel;
  end

  // Responses to free ids are dropped here and by the tracker.
  assign rsp_live      = fb_rsp_valid & rsp_alloc & ~rsp_stale & ~flush;
  assign dmd_rsp_valid = rsp_live & ~rsp_pf;
  assign pf_rsp_valid  = rsp_live & rsp_pf;

  always_ff @(posedge clk) begin
    if (reset || flush || !pf_req_valid || pf_req_gnt)
      starve_cnt <= '0;
    else if (starve_cnt != SC_W'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(fb_rsp_valid && !rsp_alloc))
        else $error("fe_fb_arb: response for free id %0d", fb_rsp_id);
  end
`endif

endmodule

// File: tb/tb_fe_fb_arb.sv
// Randomized scoreboard bench for fe_fb_arb against a cycle-level behavioural model.
module tb_fe_fb_arb;

  localparam int NID    = 4;
  localparam int MAXO   = 4;
  localparam int STARVE = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        dmd_req_valid, pf_req_valid, fb_req_ready, fb_rsp_valid;
  logic [31:0] dmd_req_addr, pf_req_addr, fb_req_addr;
  logic [1:0]  fb_req_id, fb_rsp_id;
  logic        dmd_req_gnt, pf_req_gnt, fb_req_valid, dmd_rsp_valid, pf_rsp_valid;
  logic [2:0]  outstanding_cnt;

  always #5 clk = ~clk;

  fe_fb_arb dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dmd_req_valid(dmd_req_valid), .dmd_req_addr(dmd_req_addr), .dmd_req_gnt(dmd_req_gnt),
    .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr), .pf_req_gnt(pf_req_gnt),
    .fb_req_valid(fb_req_valid), .fb_req_addr(fb_req_addr), .fb_req_id(fb_req_id),
    .fb_req_ready(fb_req_ready), .fb_rsp_valid(fb_rsp_valid), .fb_rsp_id(fb_rsp_id),
    .dmd_rsp_valid(dmd_rsp_valid), .pf_rsp_valid(pf_rsp_valid),
    .outstanding_cnt(outstanding_cnt)
  );

  typedef struct {
    bit          chk;
    bit          valid;
    logic [31:0] addr;
    logic [1:0]  id;
    bit          dgnt, pgnt, drsp, prsp;
    logic [2:0]  cnt;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Actual DUT activity, logged for the directed checks.
  int   act_dmd_ids [$];
  int   act_pf_gnts = 0;
  int   act_drsp = 0;
  int   act_prsp = 0;

  // Reference model: which ids are in flight, who owns them, which are stale.
  bit   m_busy [NID];
  bit   m_stale [NID];
  bit   m_pf [NID];
  int   m_mode = M_IDLE;
  int   m_starve = 0;
  int   m_last = -1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        cmp("fb_req_valid", 32'(fb_req_valid), 32'(e.valid));
        cmp("fb_req_addr", fb_req_addr, e.addr);
        cmp("fb_req_id", 32'(fb_req_id), 32'(e.id));
        cmp("dmd_req_gnt", 32'(dmd_req_gnt), 32'(e.dgnt));
        cmp("pf_req_gnt", 32'(pf_req_gnt), 32'(e.pgnt));
        cmp("dmd_rsp_valid", 32'(dmd_rsp_valid), 32'(e.drsp));
        cmp("pf_rsp_valid", 32'(pf_rsp_valid), 32'(e.prsp));
        cmp("outstanding_cnt", 32'(outstanding_cnt), 32'(e.cnt));
      end
      if (dmd_req_gnt) act_dmd_ids.push_back(int'(fb_req_id));
      if (pf_req_gnt) act_pf_gnts++;
      if (dmd_rsp_valid) act_drsp++;
      if (pf_rsp_valid) act_prsp++;
    end
  end

  task automatic step(input bit rst, input bit fl, input bit dv, input logic [31:0] da,
                      input bit pv, input logic [31:0] pa, input bit rdy,
                      input bit rv, input logic [1:0] rid);
    exp_t e;
    int   nb, lf;
    bit   pfw, v, any_stale;
    @(posedge clk);
    #1;
    reset = rst; flush = fl;
    dmd_req_valid = dv; dmd_req_addr = da;
    pf_req_valid = pv; pf_req_addr = pa;
    fb_req_ready = rdy; fb_rsp_valid = rv; fb_rsp_id = rid;
    nb = 0; lf = -1;
    for (int i = NID - 1; i >= 0; i--) begin
      if (m_busy[i]) nb++;
      else lf = i;
    end
    pfw     = pv && (!dv || m_starve == STARVE);
    v       = (m_mode == M_RUN) && !fl && (pv || dv) && nb < MAXO && lf >= 0;
    e.chk   = !rst;
    e.valid = v;
    e.addr  = v ? (pfw ? pa : da) : 32'h0;
    e.id    = v ? 2'(lf) : 2'd0;
    e.dgnt  = v && rdy && !pfw;
    e.pgnt  = v && rdy && pfw;
    e.drsp  = rv && m_busy[rid] && !m_stale[rid] && !fl && !m_pf[rid];
    e.prsp  = rv && m_busy[rid] && !m_stale[rid] && !fl && m_pf[rid];
    e.cnt   = 3'(nb);
    exp_q.push_back(e);
    m_last = -1;
    if (rst) begin
      for (int i = 0; i < NID; i++) begin
        m_busy[i] = 0; m_stale[i] = 0; m_pf[i] = 0;
      end
      m_mode = M_IDLE;
      m_starve = 0;
    end else begin
      if (fl || !pv || e.pgnt) m_starve = 0;
      else if (m_starve < STARVE) m_starve++;
      if (fl)
        for (int i = 0; i < NID; i++) if (m_busy[i]) m_stale[i] = 1;
      if (rv && m_busy[rid]) begin
        m_busy[rid] = 0; m_stale[rid] = 0;
      end
      if (e.dgnt || e.pgnt) begin
        m_busy[lf] = 1; m_stale[lf] = 0; m_pf[lf] = e.pgnt; m_last = lf;
      end
      any_stale = 0;
      for (int i = 0; i < NID; i++) any_stale |= m_stale[i];
      case (m_mode)
        M_IDLE: m_mode = M_RUN;
        M_RUN:  if (fl) m_mode = M_HOLD;
`ifdef FE_FB_ARB_DRAIN_EN
        M_HOLD: m_mode = fl ? M_HOLD : M_DRAIN;
        M_DRAIN: if (fl) m_mode = M_HOLD; else if (!any_stale) m_mode = M_RUN;
`else
        M_HOLD: m_mode = fl ? M_HOLD : M_RUN;
`endif
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic idle_step(input bit rv, input logic [1:0] rid);
    step(0, 0, 0, 32'h0, 0, 32'h0, 1, rv, rid);
  endtask

  task automatic dmd_step(input bit rv, input logic [1:0] rid);
    step(0, 0, 1, 32'h1000, 0, 32'h0, 1, rv, rid);
  endtask

  task automatic settle_and_clear_logs();
    @(negedge clk);
    #1;
    act_dmd_ids.delete();
    act_pf_gnts = 0; act_drsp = 0; act_prsp = 0;
  endtask

  initial begin
    int   prev;
    bit   rv, dv, pv;
    logic [1:0] rid;
    int   s;

    // 1: demand stream fills all ids, stalls, resumes after one response.
    step(1, 0, 1, 32'h1000, 0, 0, 1, 0, 0);
    step(1, 0, 1, 32'h1000, 0, 0, 1, 0, 0);
    settle_and_clear_logs();
    for (int i = 0; i < 7; i++) dmd_step(0, 0);
    dmd_step(1, 2'd1);
    dmd_step(0, 0);
    settle_and_clear_logs();
    // settle cleared the log, so replay the check from a fresh run instead
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    settle_and_clear_logs();
    for (int i = 0; i < 7; i++) dmd_step(0, 0);
    dmd_step(1, 2'd1);
    dmd_step(0, 0);
    @(negedge clk);
    #1;
    cmp("t1_grant_count", act_dmd_ids.size(), 5);
    if (act_dmd_ids.size() == 5) begin
      cmp("t1_id0", act_dmd_ids[0], 0);
      cmp("t1_id1", act_dmd_ids[1], 1);
      cmp("t1_id2", act_dmd_ids[2], 2);
      cmp("t1_id3", act_dmd_ids[3], 3);
      cmp("t1_id_reuse", act_dmd_ids[4], 1);
    end

    // 2: both requesters always on, responses one cycle after issue.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    settle_and_clear_logs();
    prev = -1;
    for (int i = 0; i < 37; i++) begin
      step(0, 0, 1, 32'h2000 + 32'(i), 1, 32'h9000 + 32'(i), 1, prev >= 0, 2'(prev < 0 ? 0 : prev));
      prev = m_last;
    end
    @(negedge clk);
    #1;
    cmp("t2_pf_grants", act_pf_gnts, 4);

    // 3: flush with ids 0 and 1 in flight; late responses are dropped.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    settle_and_clear_logs();
    idle_step(0, 0);
    dmd_step(0, 0);
    dmd_step(0, 0);
    step(0, 1, 1, 32'h1000, 0, 0, 1, 0, 0);
    dmd_step(0, 0);
    idle_step(1, 2'd0);
    idle_step(1, 2'd1);
    idle_step(0, 0);
    @(negedge clk);
    #1;
    cmp("t3_grants", act_dmd_ids.size(), 2);
    cmp("t3_dmd_rsp", act_drsp, 0);
    cmp("t3_cnt_after", 32'(outstanding_cnt), 0);

    // 4: response for id 2 (prefetch-owned) in the same cycle as a grant.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    settle_and_clear_logs();
    idle_step(0, 0);
    dmd_step(0, 0);
    step(0, 0, 0, 0, 1, 32'hA000, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'hA040, 1, 0, 0);
    idle_step(1, 2'd0);
    step(0, 0, 1, 32'h3000, 0, 0, 1, 1, 2'd2);
    idle_step(0, 0);
    @(negedge clk);
    #1;
    cmp("t4_pf_rsp", act_prsp, 1);
    cmp("t4_cnt", 32'(outstanding_cnt), 2);

`ifdef FE_FB_ARB_DRAIN_EN
    // 5: drain holds grants until the last stale response returns.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    settle_and_clear_logs();
    idle_step(0, 0);
    for (int i = 0; i < 3; i++) dmd_step(0, 0);
    step(0, 1, 1, 32'h1000, 0, 0, 1, 0, 0);
    dmd_step(0, 0);
    dmd_step(1, 2'd0);
    dmd_step(0, 0);
    dmd_step(1, 2'd1);
    dmd_step(1, 2'd2);
    dmd_step(0, 0);
    @(negedge clk);
    #1;
    cmp("t5_grants", act_dmd_ids.size(), 4);
`endif

    // 6: reset with ids in flight and a request pending.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle_step(0, 0);
    dmd_step(0, 0);
    dmd_step(0, 0);
    step(1, 0, 1, 32'h1000, 0, 0, 1, 0, 0);
    dmd_step(0, 0);
    @(negedge clk);
    #1;
    cmp("t6_cnt", 32'(outstanding_cnt), 0);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 1200; i++) begin
      rv = 0; rid = 0;
      if ($urandom_range(0, 2) != 0) begin
        s = int'($urandom_range(0, NID - 1));
        for (int k = 0; k < NID; k++)
          if (!rv && m_busy[(s + k) % NID]) begin
            rv = 1; rid = 2'((s + k) % NID);
          end
      end
      dv = ($urandom_range(0, 3) != 0);
      pv = ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           dv, $urandom, pv, $urandom, $urandom_range(0, 4) != 0, rv, rid);
    end

    @(negedge clk);
    #1;
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
